pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/pc_reg.sv | 30 +++
 rtl/pc_control.sv | 119 +++++++++++
 tb/tb_pc_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared fetch-control encodings and defaults
// Revision     : 1.0
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_t;

    localparam int unsigned c_default_step         = 4;
    localparam int unsigned c_default_reset_vector = 0;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// pc_reg : B-bit program-counter register, sync reset to RESET_VECTOR
// Revision : 1.0
// ============================================================================
module pc_reg #(
    parameter int unsigned    B            = 32,
    parameter logic [B-1:0]   RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [B-1:0] d,
    output logic [B-1:0] q
);

    logic [B-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VECTOR;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/pc_control.sv
`default_nettype none
// ============================================================================
// pc_control : debug-gated fetch FSM with prioritised next-PC selection
// Revision   : 1.0
// ============================================================================
module pc_control
    import pipeline_pkg::*;
#(
    parameter int unsigned  B            = 32,
    parameter int unsigned  STEP         = c_default_step,
    parameter logic [B-1:0] RESET_VECTOR = B'(c_default_reset_vector),
    parameter int unsigned  ALIGN_BITS   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         step,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [B-1:0] branch_target,
    input  logic         jump,
    input  logic [B-1:0] jump_target,
    input  logic         halt,
    output logic [B-1:0] pc_out,
    output logic [B-1:0] pc_plus_step,
    output logic         fetch_valid,
    output logic         misaligned,
    output logic [1:0]   state,
    output logic [B-1:0] advance_count
);

    pc_state_t    r_state;
    logic [B-1:0] r_count;
    logic         r_mis;

    pc_state_t    w_next_state;
    logic [B-1:0] w_next_pc;
    logic         w_we;
    logic         w_set_mis;
    logic         w_redirect;
    logic         w_active;
    logic [B-1:0] w_target;
    logic         w_target_bad;

    assign pc_plus_step = pc_out + B'(STEP);
    assign w_redirect   = branch_taken | jump;
    assign w_target     = branch_taken ? branch_target : jump_target;
    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);

    generate
        if (ALIGN_BITS > 0) begin : g_align_check
            assign w_target_bad = |w_target[ALIGN_BITS-1:0];
        end else begin : g_no_align_check
            assign w_target_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = pc_out;
        w_we         = 1'b0;
        w_set_mis    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable)    w_next_state = ST_RUN;
                else if (step) w_next_state = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                // RUN keeps going only while enable holds; the update below still lands this cycle
                w_next_state = (r_state == ST_RUN && enable) ? ST_RUN : ST_IDLE;
                if (halt) begin
                    w_next_state = ST_HALTED;
                end else if (w_redirect) begin
                    if (w_target_bad) begin
                        w_set_mis    = 1'b1;
                        w_next_state = ST_HALTED;
                    end else begin
                        w_we      = 1'b1;
                        w_next_pc = w_target;
                    end
                end else if (!stall) begin
                    w_we      = 1'b1;
                    w_next_pc = pc_plus_step;
                end
            end
            default: w_next_state = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_we)      r_count <= r_count + 1'b1;
            if (w_set_mis) r_mis   <= 1'b1;
        end
    end

    pc_reg #(
        .B            (B),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .d     (w_next_pc),
        .q     (pc_out)
    );

    assign fetch_valid   = !reset && w_active && (!stall || w_redirect);
    assign misaligned    = r_mis;
    assign state         = r_state;
    assign advance_count = r_count;

endmodule : pc_control
`default_nettype wire

// File: tb/tb_pc_control.sv
`default_nettype none
// ============================================================================
// tb_pc_control : scoreboard bench for pc_control (B=32 and B=8 instances)
// Revision      : 1.0
// ============================================================================
module tb_pc_control;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic        rst, en, stp, stl, br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        hl;
        logic        fv;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, step, stall, branch_taken, jump, halt;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus_step, advance_count;
    logic        fetch_valid, misaligned;
    logic [1:0]  state;
    logic [7:0]  pc8, pps8, cnt8;
    logic        fv8, mis8;
    logic [1:0]  st8;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    pc_control #(.B(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .pc_out(pc_out), .pc_plus_step(pc_plus_step), .fetch_valid(fetch_valid),
        .misaligned(misaligned), .state(state), .advance_count(advance_count)
    );

    pc_control #(.B(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
        .jump(jump), .jump_target(jump_target[7:0]), .halt(halt),
        .pc_out(pc8), .pc_plus_step(pps8), .fetch_valid(fv8),
        .misaligned(mis8), .state(st8), .advance_count(cnt8)
    );

    function automatic vec_t mk(logic rst, logic en, logic stp, logic stl, logic br,
                                logic [31:0] bt, logic jp, logic [31:0] jt, logic hl,
                                logic fv, logic [31:0] pc, logic [1:0] st,
                                logic [31:0] cnt, logic mis);
        vec_t v;
        v.rst = rst; v.en = en; v.stp = stp; v.stl = stl; v.br = br; v.bt = bt;
        v.jp = jp; v.jt = jt; v.hl = hl; v.fv = fv;
        v.e.pc = pc; v.e.st = st; v.e.cnt = cnt; v.e.mis = mis;
        return v;
    endfunction

    // Drive inputs one cycle ahead of the edge and enqueue the post-edge expectation.
    task automatic drive(input vec_t v);
        reset = v.rst; enable = v.en; step = v.stp; stall = v.stl;
        branch_taken = v.br; branch_target = v.bt; jump = v.jp; jump_target = v.jt;
        halt = v.hl;
        sbq.push_back(v.e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string name, input vec_t v[$]);
        exp_t e, got;
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (fetch_valid !== v[i].fv) begin
                errors++;
                $display("FAIL %s[%0d] fetch_valid: got %b want %b", name, i, fetch_valid, v[i].fv);
            end
            tick();
            e   = sbq.pop_front();
            got = {pc_out, state, advance_count, misaligned};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s[%0d] state: got pc=%h st=%0d cnt=%0d mis=%b want pc=%h st=%0d cnt=%0d mis=%b",
                         name, i, pc_out, state, advance_count, misaligned, e.pc, e.st, e.cnt, e.mis);
            end
            checks++;
            if (pc_plus_step !== e.pc + 32'd4) begin
                errors++;
                $display("FAIL %s[%0d] pc_plus_step: got %h want %h", name, i, pc_plus_step, e.pc + 32'd4);
            end
        end
    endtask

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk(1,1,0,0,0,0,0,0,0, 0, 32'h0,2'd0,0,0));
        v.push_back(mk(1,0,1,0,1,32'h40,0,0,0, 0, 32'h0,2'd0,0,0));
        run32("test_reset", v);
    endtask

    task automatic test_run_seq();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h0, 2'd1,0,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 1, 32'h4, 2'd1,1,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 1, 32'h8, 2'd1,2,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 1, 32'hC, 2'd1,3,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h10,2'd0,4,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 0, 32'h10,2'd0,4,0));
        run32("test_run_seq", v);
    endtask

    task automatic test_stall();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h10,2'd1,4,0));
        v.push_back(mk(0,1,0,1,0,0,0,0,0, 0, 32'h10,2'd1,4,0));
        v.push_back(mk(0,1,0,1,0,0,0,0,0, 0, 32'h10,2'd1,4,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 1, 32'h14,2'd1,5,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h18,2'd0,6,0));
        run32("test_stall", v);
    endtask

    task automatic test_redirect();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h18, 2'd1,6,0));
        v.push_back(mk(0,1,0,1,1,32'h100,1,32'h200,0, 1, 32'h100,2'd1,7,0));
        v.push_back(mk(0,1,0,1,0,0,1,32'h300,0, 1, 32'h300,2'd1,8,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h304,2'd0,9,0));
        run32("test_redirect", v);
    endtask

    task automatic test_step();
        vec_t v[$];
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 0, 32'h0, 2'd0,0,0));
        v.push_back(mk(0,0,1,0,0,0,0,0,0, 0, 32'h0, 2'd2,0,0));
        v.push_back(mk(1,1,0,0,0,0,0,0,0, 0, 32'h0, 2'd0,0,0));
        v.push_back(mk(0,0,1,0,0,0,0,0,0, 0, 32'h0, 2'd2,0,0));
        v.push_back(mk(0,0,0,0,0,0,1,32'h20,0, 1, 32'h20,2'd0,1,0));
        v.push_back(mk(0,0,1,0,0,0,0,0,0, 0, 32'h20,2'd2,1,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h24,2'd0,2,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 0, 32'h24,2'd0,2,0));
        v.push_back(mk(0,0,1,0,0,0,0,0,0, 0, 32'h24,2'd2,2,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h28,2'd0,3,0));
        run32("test_step", v);
    endtask

    task automatic test_misalign_halt();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h28,2'd1,3,0));
        v.push_back(mk(0,1,0,0,0,0,1,32'h202,0, 1, 32'h28,2'd3,3,1));
        v.push_back(mk(0,1,1,0,1,32'h400,0,0,0, 0, 32'h28,2'd3,3,1));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 0, 32'h0, 2'd0,0,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h0, 2'd1,0,0));
        v.push_back(mk(0,1,0,0,1,32'h80,0,0,1, 1, 32'h0, 2'd3,0,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h0, 2'd3,0,0));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 0, 32'h0, 2'd0,0,0));
        run32("test_misalign_halt", v);
    endtask

    task automatic test_wrap8();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 0, 32'h00,2'd0,0,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 0, 32'h00,2'd1,0,0));
        v.push_back(mk(0,1,0,0,1,32'hFC,0,0,0, 1, 32'hFC,2'd1,1,0));
        v.push_back(mk(0,1,0,0,0,0,0,0,0, 1, 32'h00,2'd1,2,0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 1, 32'h04,2'd0,3,0));
        foreach (v[i]) begin
            drive(v[i]);
            checks++;
            if (fv8 !== v[i].fv) begin
                errors++;
                $display("FAIL test_wrap8[%0d] fetch_valid: got %b want %b", i, fv8, v[i].fv);
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if ({pc8, st8, cnt8, mis8} !== {e.pc[7:0], e.st, e.cnt[7:0], e.mis}) begin
                errors++;
                $display("FAIL test_wrap8[%0d] state: got pc=%h st=%0d cnt=%0d mis=%b want pc=%h st=%0d cnt=%0d mis=%b",
                         i, pc8, st8, cnt8, mis8, e.pc[7:0], e.st, e.cnt[7:0], e.mis);
            end
            checks++;
            if (pps8 !== 8'(e.pc[7:0] + 8'd4)) begin
                errors++;
                $display("FAIL test_wrap8[%0d] pc_plus_step: got %h want %h", i, pps8, 8'(e.pc[7:0] + 8'd4));
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; step = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
        tick();
        test_reset();
        test_run_seq();
        test_stall();
        test_redirect();
        test_step();
        test_misalign_halt();
        test_wrap8();
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_control
`default_nettype wire
